syndrome_loader: RTL

SYNDROME_LOADER -- requirements
Module: syndrome_loader

---
 rtl/syndrome_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/syndrome_loader.sv
// Serial syndrome loader: shifts in one bit per PE, strobes the grid, times the offer, drains PE matches.
// Optional LOADER_SKIP_EMPTY_EN: all-zero frames bypass the offer and drain zeros.
module syndrome_loader #(
    parameter int NUM_PE            = 6,
    parameter int MATCH_VALUE_WIDTH = 8,
    parameter int OFFER_CYCLES      = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                syn_in_bit,
    input  logic                                syn_in_valid,
    output logic                                syn_in_ready,
    output logic [NUM_PE-1:0]                   measurement_value_out,
    output logic [NUM_PE-1:0]                   measurement_valid_out,
    output logic                                start_offer,
    output logic                                stop_offer,
    input  logic [NUM_PE*MATCH_VALUE_WIDTH-1:0] match_value_in,
    output logic [MATCH_VALUE_WIDTH-1:0]        result_value,
    output logic [((NUM_PE > 1) ? $clog2(NUM_PE) : 1)-1:0] result_index,
    output logic                                result_last,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic                                busy
);

    localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int MW = MATCH_VALUE_WIDTH;

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_PUSH  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [15:0]          ocnt_q, ocnt_d;
    logic [NUM_PE-1:0]    meas_q, meas_d;
    logic [NUM_PE*MW-1:0] snap_q, snap_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 arm_q, arm_d;
    logic                 last_idx;

    // arm_q keeps syn_in_ready low until the first edge after reset release
    assign arm_d    = 1'b1;
    assign last_idx = (idx_q == IW'(NUM_PE - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ocnt_d  = ocnt_q;
        meas_d  = meas_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        case (state_q)
            S_LOAD: begin
                if (syn_in_valid && syn_in_ready) begin
                    meas_d[cnt_q] = syn_in_bit;
                    if (cnt_q == IW'(NUM_PE - 1)) begin
                        cnt_d   = '0;
                        state_d = S_PUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PUSH: begin
`ifdef LOADER_SKIP_EMPTY_EN
                if (meas_q == '0) begin
                    snap_d  = '0;
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_START;
                end
`else
                state_d = S_START;
`endif
            end
            S_START: begin
                ocnt_d  = 16'(OFFER_CYCLES - 1);
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ocnt_q == '0) begin
                    state_d = S_STOP;
                end else begin
                    ocnt_d = ocnt_q - 1'b1;
                end
            end
            S_STOP: begin
                snap_d  = match_value_in;
                idx_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (result_ready) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            ocnt_q  <= '0;
            meas_q  <= '0;
            snap_q  <= '0;
            idx_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ocnt_q  <= ocnt_d;
            meas_q  <= meas_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            arm_q   <= arm_d;
        end
    end

    assign syn_in_ready          = arm_q && (state_q == S_LOAD);
    assign measurement_value_out = meas_q;
    assign measurement_valid_out = {NUM_PE{state_q == S_PUSH}};
    assign start_offer           = (state_q == S_START);
    assign stop_offer            = (state_q == S_STOP);
    assign result_valid          = (state_q == S_DRAIN);
    assign result_value          = snap_q[idx_q*MW +: MW];
    assign result_index          = idx_q;
    assign result_last           = result_valid && last_idx;
    assign busy                  = !((state_q == S_LOAD) && (cnt_q == '0));

endmodule
